// File: rtl/seg7_dr_scan_ctrl.sv
// Four-phase dual-rail receiver keeping the last NUM_SLOTS words, scanned onto one shared decoder.
// Latency: dr_in edge to ack edge 4 clk; dr_out/an_n trail the scan index by 1 clk. Flow control is the ack handshake only.
module seg7_dr_scan_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int SCAN_DIV  = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           dr_in,
  output logic                 ack,
  input  logic                 clr,
  output logic [7:0]           dr_out,
  output logic [NUM_SLOTS-1:0] an_n,
  output logic                 err,
  output logic [7:0]           word_cnt
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SLOTS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [NUM_SLOTS-1:0] AN_RST = {{(NUM_SLOTS-1){1'b1}}, 1'b0};

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]           r_sync1;
  logic [7:0]           r_sync2;
  logic [7:0]           r_prev;
  logic                 r_ack;
  logic                 w_ack_nxt;
  logic                 r_err;
  logic [7:0]           r_word_cnt;
  logic [7:0]           r_slot [NUM_SLOTS];
  logic [IDX_W-1:0]     r_idx;
  logic [PRE_W-1:0]     r_pre;
  logic [7:0]           r_dr_out;
  logic [NUM_SLOTS-1:0] r_an_n;

  logic w_push;
  logic w_set_err;
  logic w_complete;
  logic w_has_11;
  logic w_any_null;
  logic w_null;
  logic w_stable;

  // Pair classification of the synchronized word.
  always_comb begin
    w_complete = 1'b1;
    w_has_11   = 1'b0;
    w_any_null = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (r_sync2[2*i+1] == r_sync2[2*i]) w_complete = 1'b0;
      if (r_sync2[2*i+1] &  r_sync2[2*i]) w_has_11   = 1'b1;
      if (!(r_sync2[2*i+1] | r_sync2[2*i])) w_any_null = 1'b1;
    end
  end

  assign w_null   = (r_sync2 == 8'h00);
  assign w_stable = (r_sync2 == r_prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
      r_prev  <= 8'h00;
    end else begin
      r_sync1 <= dr_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_push      = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      WAIT_DATA: begin
        if (w_stable && w_complete) begin
          w_push      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = WAIT_NULL;
        end else if (w_stable && w_has_11 && !w_any_null) begin
          w_set_err = 1'b1;
        end
      end
      WAIT_NULL: begin
        if (w_stable && w_null) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = WAIT_DATA;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= WAIT_DATA;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_word_cnt <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      if (w_set_err) r_err <= 1'b1;
      if (w_push) r_word_cnt <= r_word_cnt + 8'd1;
    end
  end

  // clr wipes the older entries but never loses a word being pushed this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) r_slot[k] <= 8'h00;
    end else if (clr) begin
      for (int k = 0; k < NUM_SLOTS; k++) r_slot[k] <= 8'h00;
      if (w_push) r_slot[0] <= r_sync2;
    end else if (w_push) begin
      r_slot[0] <= r_sync2;
      for (int k = 1; k < NUM_SLOTS; k++) r_slot[k] <= r_slot[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_dr_out <= 8'h00;
      r_an_n   <= AN_RST;
    end else begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_dr_out <= r_slot[r_idx];
      r_an_n   <= ~(NUM_SLOTS'(1) << r_idx);
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign word_cnt = r_word_cnt;
  assign dr_out   = r_dr_out;
  assign an_n     = r_an_n;

endmodule

// File: tb/tb_seg7_dr_scan_ctrl.sv
// Bench for seg7_dr_scan_ctrl: vector table, directed corner sequences and random handshakes vs a slot-history model.
module tb_seg7_dr_scan_ctrl;
  localparam int N   = 4;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic [7:0]   dr_in;
  logic         ack;
  logic [7:0]   dr_out;
  logic [N-1:0] an_n;
  logic         err;
  logic [7:0]   word_cnt;

  seg7_dr_scan_ctrl #(.NUM_SLOTS(N), .SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .dr_in(dr_in), .ack(ack), .clr(clr),
    .dr_out(dr_out), .an_n(an_n), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_slot [N];
  int         m_cnt;
  logic       m_err;

  typedef struct {
    logic [7:0] w;
    int         hold;
    logic       exp_ack;
    logic       exp_err;
  } vec_t;
  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic is_complete(input logic [7:0] w);
    for (int i = 0; i < 4; i++) begin
      int p = (int'(w) >> (2*i)) % 4;
      if (p != 1 && p != 2) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic is_illegal(input logic [7:0] w);
    logic any3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int p = (int'(w) >> (2*i)) % 4;
      if (p == 0) return 1'b0;
      if (p == 3) any3 = 1'b1;
    end
    return any3;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < N; k++) m_slot[k] = 8'h00;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic m_push(input logic [7:0] w);
    for (int k = N-1; k > 0; k--) m_slot[k] = m_slot[k-1];
    m_slot[0] = w;
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; dr_in = 8'h00;
    tick(); tick();
    rst = 1'b0;
    m_reset();
  endtask

  // Present w for hold cycles, look at ack 4 cycles after it appeared, then release to null.
  task automatic send(input logic [7:0] w, input int hold, output logic ack_seen);
    dr_in = w;
    for (int i = 0; i < hold; i++) tick();
    dr_in = 8'h00;
    for (int i = hold; i < 4; i++) tick();
    ack_seen = ack;
    repeat (4) tick();
    chk("ack_release", ack, 1'b0);
    if (hold >= 2) begin
      if (is_complete(w)) m_push(w);
      else if (is_illegal(w)) m_err = 1'b1;
    end
  endtask

  task automatic readback(input string tag);
    logic [7:0] got  [N];
    logic       seen [N];
    logic       onehot_ok;
    int         idx;
    int         zeros;
    onehot_ok = 1'b1;
    for (int j = 0; j < N; j++) begin got[j] = 8'h00; seen[j] = 1'b0; end
    for (int c = 0; c < N*DIV + 2; c++) begin
      tick();
      zeros = 0; idx = 0;
      for (int j = 0; j < N; j++) if (an_n[j] === 1'b0) begin zeros++; idx = j; end
      if (zeros != 1) onehot_ok = 1'b0;
      else begin got[idx] = dr_out; seen[idx] = 1'b1; end
    end
    chk($sformatf("%s_an_onehot", tag), onehot_ok, 1'b1);
    for (int j = 0; j < N; j++)
      chk($sformatf("%s_slot%0d", tag, j), seen[j] ? {24'h0, got[j]} : 32'hDEAD, {24'h0, m_slot[j]});
  endtask

  task automatic scan_cadence();
    logic [N-1:0] prev_an;
    int last;
    int changes;
    last = -1; changes = 0;
    prev_an = an_n;
    for (int t = 0; t < 12*DIV; t++) begin
      tick();
      if (an_n !== prev_an) begin
        chk("scan_order", an_n, {prev_an[N-2:0], prev_an[N-1]});
        if (last >= 0) chk("scan_dwell", t - last, DIV);
        last = t;
        prev_an = an_n;
        changes++;
      end
    end
    chk("scan_changes", changes >= 8, 1'b1);
  endtask

  initial begin
    logic       a;
    logic [7:0] w;
    logic [1:0] p;
    int         kind;
    int         hold;
    logic       exp_acc;

    tbl[0]  = '{8'h56, 6, 1'b1, 1'b0};
    tbl[1]  = '{8'hA5, 4, 1'b1, 1'b0};
    tbl[2]  = '{8'h50, 6, 1'b0, 1'b0};
    tbl[3]  = '{8'h00, 6, 1'b0, 1'b0};
    tbl[4]  = '{8'h96, 1, 1'b0, 1'b0};
    tbl[5]  = '{8'h96, 2, 1'b1, 1'b0};
    tbl[6]  = '{8'h5A, 3, 1'b1, 1'b0};
    tbl[7]  = '{8'h57, 5, 1'b0, 1'b1};
    tbl[8]  = '{8'h6A, 5, 1'b1, 1'b1};
    tbl[9]  = '{8'hFF, 4, 1'b0, 1'b1};
    tbl[10] = '{8'h9A, 7, 1'b1, 1'b1};

    rst = 1'b1; clr = 1'b0; dr_in = 8'h00;
    tick(); tick();
    chk("rst_ack", ack, 1'b0);
    chk("rst_dr_out", dr_out, 8'h00);
    chk("rst_an_n", an_n, 4'b1110);
    chk("rst_err", err, 1'b0);
    chk("rst_word_cnt", word_cnt, 8'h00);
    rst = 1'b0;
    m_reset();
    readback("rst");

    // Exact handshake timing.
    dr_in = 8'h56;
    repeat (3) tick();
    chk("t1_ack_c3", ack, 1'b0);
    tick();
    chk("t1_ack_c4", ack, 1'b1);
    chk("t1_cnt", word_cnt, 8'd1);
    repeat (2) tick();
    dr_in = 8'h00;
    repeat (3) tick();
    chk("t1_ackoff_c3", ack, 1'b1);
    tick();
    chk("t1_ackoff_c4", ack, 1'b0);
    m_push(8'h56);
    readback("t1");

    do_reset();
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].w, tbl[i].hold, a);
      chk($sformatf("tbl%0d_ack", i), a, tbl[i].exp_ack);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      chk($sformatf("tbl%0d_cnt", i), word_cnt, m_cnt[7:0]);
    end
    readback("tbl");

    do_reset();
    send(8'h55, 4, a); send(8'h56, 4, a); send(8'h59, 4, a); send(8'h5A, 4, a); send(8'h65, 4, a);
    chk("t2_cnt", word_cnt, 8'd5);
    readback("t2");

    do_reset();
    send(8'h55, 4, a); send(8'hAA, 4, a);
    readback("t3");
    scan_cadence();

    // Glitches on the input must not be pushed.
    dr_in = 8'h50; tick();
    send(8'h96, 5, a);
    chk("t5_glitch50_ack", a, 1'b1);
    dr_in = 8'hA9; tick();
    send(8'h69, 5, a);
    chk("t5_glitchA9_ack", a, 1'b1);
    chk("t5_cnt", word_cnt, m_cnt[7:0]);
    readback("t5g");

    dr_in = 8'hA6;
    repeat (3) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t5_clrpush_ack", ack, 1'b1);
    dr_in = 8'h00;
    repeat (4) tick();
    m_push(8'hA6);
    for (int k = 1; k < N; k++) m_slot[k] = 8'h00;
    chk("t5_clrpush_cnt", word_cnt, m_cnt[7:0]);
    readback("t5c");
    send(8'h5A, 3, a);
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < N; k++) m_slot[k] = 8'h00;
    chk("t5_clr_cnt", word_cnt, m_cnt[7:0]);
    readback("t5clr");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++) begin
        if (kind == 0)      p = 2'($urandom_range(1, 2));
        else if (kind == 1) p = 2'($urandom_range(0, 2));
        else                p = 2'($urandom_range(1, 3));
        w[2*i +: 2] = p;
      end
      if (kind == 2) w[2*$urandom_range(0, 3) +: 2] = 2'b11;
      hold = $urandom_range(2, 7);
      exp_acc = is_complete(w);
      send(w, hold, a);
      chk($sformatf("rnd%0d_ack_w%02h", n, w), a, exp_acc);
      chk($sformatf("rnd%0d_cnt", n), word_cnt, m_cnt[7:0]);
      chk($sformatf("rnd%0d_err", n), err, m_err);
      if (n % 8 == 7) readback("rnd");
    end

    // Reset in the middle of a handshake, then the same word is taken again.
    dr_in = 8'h59;
    repeat (5) tick();
    chk("t6_ack_before", ack, 1'b1);
    rst = 1'b1; tick();
    chk("t6_rst_ack", ack, 1'b0);
    chk("t6_rst_an_n", an_n, 4'b1110);
    chk("t6_rst_dr_out", dr_out, 8'h00);
    chk("t6_rst_cnt", word_cnt, 8'h00);
    chk("t6_rst_err", err, 1'b0);
    rst = 1'b0;
    m_reset();
    repeat (4) tick();
    chk("t6_retry_ack", ack, 1'b1);
    m_push(8'h59);
    chk("t6_retry_cnt", word_cnt, m_cnt[7:0]);
    dr_in = 8'h00;
    repeat (4) tick();
    chk("t6_retry_release", ack, 1'b0);
    readback("t6");

    do_reset();
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 4; i++) w[2*i +: 2] = 2'($urandom_range(1, 2));
      send(w, 2, a);
      if (n == 254) chk("wrap_cnt255", word_cnt, 8'd255);
    end
    chk("wrap_cnt0", word_cnt, 8'd0);
    chk("wrap_model", word_cnt, m_cnt[7:0]);
    readback("wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
